// File: rtl/axi_slv_pkg.sv
// Shared types for the AXI4 slave memory: burst/response encodings, FSM states,
// and the per-burst response rule.
package axi_slv_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Decode error outranks slave error; only FIXED and INCR bursts are serviced.
    function automatic resp_t burst_resp(input logic oob, input logic size_ok, input burst_t burst);
        if (oob)
            return RESP_DECERR;
        if (!size_ok || (burst != BURST_FIXED && burst != BURST_INCR))
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_slv_mem_array.sv
// Single-clock word array with a byte-enable write port and a registered read port.
// The read register only updates when re is high, so it holds data across a stalled beat.
module axi_slv_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int IDXW       = $clog2(DEPTH)
) (
    input  logic                    ACLK,
    input  logic                    we,
    input  logic [IDXW-1:0]         wr_idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    re,
    input  logic [IDXW-1:0]         rd_idx,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read samples the old word when a write hits the same index this cycle.
    always_ff @(posedge ACLK) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb[b])
                    mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re)
            rdata <= mem[rd_idx];
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by a word memory, with independent write and read FSMs.
// Define AXI_SLV_WLAST_CHECK_EN to turn a misplaced or missing WLAST into SLVERR.
module axi_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);
    import axi_slv_pkg::*;

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int IDXW  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

    wr_state_t             w_state;
    logic                  awready_q, wready_q, bvalid_q;
    logic [ID_WIDTH-1:0]   bid_q;
    resp_t                 bresp_q, w_resp, final_resp;
    logic [IDXW-1:0]       w_idx;
    logic [7:0]            w_cnt;
    burst_t                w_burst;

    rd_state_t             r_state;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [ID_WIDTH-1:0]   rid_q;
    resp_t                 rresp_q;
    logic [IDXW-1:0]       r_idx, r_idx_nxt, rd_idx;
    logic [7:0]            r_cnt;
    burst_t                r_burst;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, mem_we, mem_re;
    resp_t aw_resp, ar_resp;

    assign aw_hs = AWVALID && awready_q;
    assign w_hs  = WVALID && wready_q;
    assign b_hs  = bvalid_q && BREADY;
    assign ar_hs = ARVALID && arready_q;
    assign r_hs  = rvalid_q && RREADY;

    assign aw_resp = burst_resp({1'b0, AWADDR} >= MEM_BYTES, AWSIZE == 3'(OFS), burst_t'(AWBURST));
    assign ar_resp = burst_resp({1'b0, ARADDR} >= MEM_BYTES, ARSIZE == 3'(OFS), burst_t'(ARBURST));

`ifdef AXI_SLV_WLAST_CHECK_EN
    logic wlast_bad;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            wlast_bad <= 1'b0;
        else if (aw_hs)
            wlast_bad <= 1'b0;
        else if (w_hs && (WLAST != (w_cnt == 8'd0)))
            wlast_bad <= 1'b1;
    end

    // On the final beat a missing WLAST is folded in alongside earlier stray ones.
    assign final_resp = (w_resp == RESP_OKAY && (wlast_bad || !WLAST)) ? RESP_SLVERR : w_resp;
`else
    logic unused_wlast;
    assign unused_wlast = WLAST;
    assign final_resp   = w_resp;
`endif

    // Write FSM: the beat counter alone ends the burst.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            w_resp    <= RESP_OKAY;
            w_idx     <= '0;
            w_cnt     <= '0;
            w_burst   <= BURST_FIXED;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_hs) begin
                        bid_q     <= AWID;
                        w_resp    <= aw_resp;
                        w_idx     <= AWADDR[OFS +: IDXW];
                        w_cnt     <= AWLEN;
                        w_burst   <= burst_t'(AWBURST);
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (w_burst == BURST_INCR)
                            w_idx <= w_idx + IDXW'(1);
                        w_cnt <= w_cnt - 8'd1;
                        if (w_cnt == 8'd0) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= final_resp;
                            w_state  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign r_idx_nxt = (r_burst == BURST_INCR) ? r_idx + IDXW'(1) : r_idx;

    // Fetch beat 0 on the AR handshake and each following beat as the current one retires.
    assign mem_re = ar_hs || (r_hs && !rlast_q);
    assign rd_idx = ar_hs ? ARADDR[OFS +: IDXW] : r_idx_nxt;
    assign mem_we = w_hs && (w_resp == RESP_OKAY);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_burst   <= BURST_FIXED;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        rid_q     <= ARID;
                        rresp_q   <= ar_resp;
                        r_idx     <= ARADDR[OFS +: IDXW];
                        r_cnt     <= ARLEN;
                        r_burst   <= burst_t'(ARBURST);
                        rlast_q   <= (ARLEN == 8'd0);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_idx   <= r_idx_nxt;
                            r_cnt   <= r_cnt - 8'd1;
                            rlast_q <= (r_cnt == 8'd1);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    axi_slv_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDXW       (IDXW)
    ) u_mem (
        .ACLK   (ACLK),
        .we     (mem_we),
        .wr_idx (w_idx),
        .wdata  (WDATA),
        .wstrb  (WSTRB),
        .re     (mem_re),
        .rd_idx (rd_idx),
        .rdata  (mem_rdata)
    );

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
    assign RRESP   = rresp_q;
    // Out-of-range reads return zero; the array word behind a wrapped index is never exposed.
    assign RDATA   = (rvalid_q && rresp_q != RESP_DECERR) ? mem_rdata : '0;

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem
Interface
REQ-001 ADDR_WIDTH, 32, address bus width SHALL be a parameter.
REQ-002 DATA_WIDTH, 32, data bus width SHALL be a parameter.
REQ-003 ID_WIDTH, 4, transaction ID width SHALL be a parameter.
REQ-004 MEM_DEPTH, 256, number of DATA_WIDTH words of backing store SHALL be a parameter.
REQ-005 ACLK  in  1  clock; all logic SHALL be clocked on the rising edge.
REQ-006 ARESETN  in  1  reset, asynchronous, active-low.
REQ-007 AWID  in  ID_WIDTH  write ID.
REQ-008 AWADDR  in  ADDR_WIDTH  write start byte address.
REQ-009 AWLEN  in  8  write beats minus one.
REQ-010 AWSIZE  in  3  write beat size.
REQ-011 AWBURST  in  2  write burst type.
REQ-012 AWVALID  in  1  write address valid.
REQ-013 AWREADY  out  1  write address ready.
REQ-014 WDATA  in  DATA_WIDTH  write data.
REQ-015 WSTRB  in  DATA_WIDTH/8  byte enables.
REQ-016 WLAST  in  1  last write beat.
REQ-017 WVALID  in  1  write data valid.
REQ-018 WREADY  out  1  write data ready.
REQ-019 BID  out  ID_WIDTH  response ID, equal to the latched AWID.
REQ-020 BRESP  out  2  write response.
REQ-021 BVALID  out  1  write response valid.
REQ-022 BREADY  in  1  write response ready.
REQ-023 ARID  in  ID_WIDTH  read ID.
REQ-024 ARADDR  in  ADDR_WIDTH  read start byte address.
REQ-025 ARLEN  in  8  read beats minus one.
REQ-026 ARSIZE  in  3  read beat size.
REQ-027 ARBURST  in  2  read burst type.
REQ-028 ARVALID  in  1  read address valid.
REQ-029 ARREADY  out  1  read address ready.
REQ-030 RID  out  ID_WIDTH  read ID, equal to the latched ARID.
REQ-031 RDATA  out  DATA_WIDTH  read data.
REQ-032 RRESP  out  2  read response.
REQ-033 RLAST  out  1  last read beat.
REQ-034 RVALID  out  1  read data valid.
REQ-035 RREADY  in  1  read data ready.
Function
REQ-036 The write FSM (W_IDLE, W_DATA, W_RESP) and the read FSM (R_IDLE, R_DATA) SHALL run independently and concurrently.
REQ-037 Write path: AWREADY=1 only in W_IDLE; on the AW handshake the block latches ID/addr/len/burst and enters W_DATA with WREADY=1 on the next cycle; each W handshake writes the bytes enabled by WSTRB; on handshake of beat AWLEN it drops WREADY, enters W_RESP, and asserts BVALID the next cycle, holding BID/BRESP until BREADY, then returns to W_IDLE.
REQ-038 Read path: ARREADY=1 only in R_IDLE; on the AR handshake the block latches and enters R_DATA, with RVALID=1 and beat 0 on the next cycle; RDATA/RRESP/RLAST are held stable while RVALID&&!RREADY; RLAST=1 only on beat ARLEN; the RLAST handshake returns the FSM to R_IDLE.
REQ-039 Addressing: word index = addr[log2(DATA_WIDTH/8)+:log2(MEM_DEPTH)]; FIXED (00) holds the address; INCR (01) adds DATA_WIDTH/8 per beat and wraps modulo MEM_DEPTH*DATA_WIDTH/8.
REQ-040 Response priority: start address >= MEM_DEPTH*DATA_WIDTH/8 -> DECERR (11), writes suppressed, RDATA=0; else size != log2(DATA_WIDTH/8) or burst WRAP/reserved -> SLVERR (10), writes suppressed; else OKAY (00); the error applies to every beat of the burst.
REQ-041 Same-cycle read and write to the same word: RDATA SHALL return the pre-write contents.
Reset
REQ-042 While ARESETN=0: both FSMs idle, all VALID/READY outputs 0, BID/BRESP/RID/RRESP/RDATA/RLAST 0; memory contents are not reset; assertion mid-burst aborts the burst with no response issued.
Configuration
REQ-043 With AXI_SLV_WLAST_CHECK_EN defined, WLAST on any beat other than AWLEN, or its absence on beat AWLEN, forces BRESP=SLVERR; without the macro, WLAST is ignored and the beat count alone ends the burst.
Structure
REQ-044 Package axi_slv_pkg SHALL hold the burst_t and resp_t enums and the wr_state_t/rd_state_t types; sub-module axi_slv_mem_array (single-clock, byte-enable write port, registered read port) SHALL hold the storage.
Verification
REQ-045 Write AWADDR=0x0, AWLEN=4, INCR, WDATA=0xA5A5A5A5, WSTRB=0xF -> five W handshakes, then BRESP=OKAY and BID=AWID.
REQ-046 Read ARADDR=0x0, ARLEN=4, INCR -> five beats of 0xA5A5A5A5, RLAST only on beat 4, RRESP=OKAY; with RREADY toggled every other cycle, RDATA stays stable while stalled.
REQ-047 Write to 0x10 with WSTRB=0x3 and WDATA=0x12345678 over a word holding 0xFFFFFFFF -> read returns 0xFFFF5678.
REQ-048 AWADDR=MEM_DEPTH*4 -> BRESP=DECERR with memory unchanged; ARBURST=WRAP -> all beats RRESP=SLVERR.
REQ-049 ARESETN dropped in the middle of W_DATA -> AWREADY=1 on the first edge after release and no BVALID; overlapping AW and AR bursts both complete correctly.
